// File: rtl/mpu_reg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// global_defs / mpu_reg_seq_ctrl
//
// Purpose
//   Sequencer between the MPU memory-side streams and mpu_register_file.
//   It accepts whole-matrix load and store commands, walks the row/column
//   indices in row-major order, drives the register file's per-element
//   load/store ports and moves elements through valid/ready streams.
//   Only one command runs at a time; load wins over store when both are
//   requested in the same cycle.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   ld_req_in / ld_ready_out        load command handshake
//   ld_addr_in, ld_m_in, ld_n_in    load target register and matrix size
//   ld_data_valid_in / ld_data_ready_out / ld_data_in
//                                   inbound element stream
//   st_req_in / st_ready_out        store command handshake
//   st_addr_in, st_m_in, st_n_in    store source register and matrix size
//   st_data_valid_out / st_data_ready_in / st_data_out / st_last_out
//                                   outbound element stream
//   busy_out                        sequencer not idle (registered)
//   done_out                        one-cycle pulse at command completion
//   err_out                         one-cycle pulse when a command is rejected
//   reg_load_*                      register-file element write port
//   reg_store_*                     register-file element read port
//   reg_store_element_in            registered read data, valid one cycle
//                                   after reg_store_en_out, held otherwise
//
// Configuration
//   MPU_SEQ_BOUNDS_CHECK_EN  when defined, commands with m==0, m>M, n==0,
//                            n>N or addr>=MATRIX_REGISTERS are rejected with
//                            an err_out pulse. When undefined err_out is
//                            always 0 and every command runs as given.
// ---------------------------------------------------------------------------

package global_defs;
  parameter int MATRIX_REGISTERS = 8;
  parameter int M                = 4;
  parameter int N                = 4;
  parameter int MBITS            = 2;
  parameter int NBITS            = 2;
  parameter int FP               = 32;
  parameter int MATRIX_REG_SIZE  = 3;
endpackage

module mpu_reg_seq_ctrl #(
  parameter int MATRIX_REGISTERS = global_defs::MATRIX_REGISTERS,
  parameter int M                = global_defs::M,
  parameter int N                = global_defs::N,
  parameter int MBITS            = global_defs::MBITS,
  parameter int NBITS            = global_defs::NBITS,
  parameter int FP               = global_defs::FP,
  parameter int MATRIX_REG_SIZE  = global_defs::MATRIX_REG_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       ld_req_in,
  output logic                       ld_ready_out,
  input  logic [MATRIX_REG_SIZE-1:0] ld_addr_in,
  input  logic [MBITS:0]             ld_m_in,
  input  logic [NBITS:0]             ld_n_in,
  input  logic                       ld_data_valid_in,
  output logic                       ld_data_ready_out,
  input  logic [FP-1:0]              ld_data_in,

  input  logic                       st_req_in,
  output logic                       st_ready_out,
  input  logic [MATRIX_REG_SIZE-1:0] st_addr_in,
  input  logic [MBITS:0]             st_m_in,
  input  logic [NBITS:0]             st_n_in,
  output logic                       st_data_valid_out,
  input  logic                       st_data_ready_in,
  output logic [FP-1:0]              st_data_out,
  output logic                       st_last_out,

  output logic                       busy_out,
  output logic                       done_out,
  output logic                       err_out,

  output logic                       reg_load_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out,
  output logic [MBITS:0]             reg_i_load_loc_out,
  output logic [NBITS:0]             reg_j_load_loc_out,
  output logic [MBITS:0]             reg_m_load_size_out,
  output logic [NBITS:0]             reg_n_load_size_out,
  output logic [FP-1:0]              reg_load_element_out,

  output logic                       reg_store_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
  output logic [MBITS:0]             reg_i_store_loc_out,
  output logic [NBITS:0]             reg_j_store_loc_out,
  input  logic [FP-1:0]              reg_store_element_in
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_STORE_RD  = 3'd2,
    S_STORE_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam logic [MBITS:0] ONE_M = (MBITS+1)'(1);
  localparam logic [NBITS:0] ONE_N = (NBITS+1)'(1);

  state_e                       state_q, state_d;
  logic [MATRIX_REG_SIZE-1:0]   addr_q, addr_d;
  logic [MBITS:0]               m_q, m_d;
  logic [NBITS:0]               n_q, n_d;
  logic [MBITS:0]               i_q, i_d;
  logic [NBITS:0]               j_q, j_d;
  logic                         err_q, err_d;

  logic                         is_idle;
  logic                         ld_accept;
  logic                         st_accept;
  logic [MATRIX_REG_SIZE-1:0]   cmd_addr;
  logic [MBITS:0]               cmd_m;
  logic [NBITS:0]               cmd_n;
  logic                         cmd_illegal;
  logic                         i_last;
  logic                         j_last;
  logic                         elem_last;

  assign is_idle   = (state_q == S_IDLE);
  assign ld_accept = is_idle & ld_req_in;
  // Store is only offered when no load is competing in the same cycle.
  assign st_accept = is_idle & st_req_in & ~ld_req_in;

  // Fields of whichever command is being accepted this cycle.
  always_comb begin
    cmd_addr = st_addr_in;
    cmd_m    = st_m_in;
    cmd_n    = st_n_in;
    if (ld_req_in) begin
      cmd_addr = ld_addr_in;
      cmd_m    = ld_m_in;
      cmd_n    = ld_n_in;
    end
  end

`ifdef MPU_SEQ_BOUNDS_CHECK_EN
  localparam logic [MBITS:0]           M_MAX   = (MBITS+1)'(M);
  localparam logic [NBITS:0]           N_MAX   = (NBITS+1)'(N);
  localparam logic [MATRIX_REG_SIZE:0] REG_CNT = (MATRIX_REG_SIZE+1)'(MATRIX_REGISTERS);

  assign cmd_illegal = (cmd_m == '0) || (cmd_m > M_MAX) ||
                       (cmd_n == '0) || (cmd_n > N_MAX) ||
                       ({1'b0, cmd_addr} >= REG_CNT);
`else
  assign cmd_illegal = 1'b0;
`endif

  // Full-width compares: m==0 makes m-1 all ones, so the walk wraps over the
  // whole counter range instead of terminating early.
  assign i_last    = (i_q == (m_q - ONE_M));
  assign j_last    = (j_q == (n_q - ONE_N));
  assign elem_last = i_last & j_last;

  // Next-state, latched command fields, row-major index walk.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    m_d     = m_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_accept || st_accept) begin
          if (cmd_illegal) begin
            // Handshake completes but nothing is latched or executed.
            err_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            m_d     = cmd_m;
            n_d     = cmd_n;
            i_d     = '0;
            j_d     = '0;
            state_d = ld_accept ? S_LOAD : S_STORE_RD;
          end
        end
      end

      S_LOAD: begin
        if (ld_data_valid_in) begin
          if (j_last) begin
            j_d = '0;
            i_d = i_q + ONE_M;
          end else begin
            j_d = j_q + ONE_N;
          end
          if (elem_last) begin
            state_d = S_DONE;
          end
        end
      end

      S_STORE_RD: begin
        state_d = S_STORE_OUT;
      end

      S_STORE_OUT: begin
        // While stalled nothing moves, so the register file keeps its read
        // data and st_data_out stays stable.
        if (st_data_ready_in) begin
          if (elem_last) begin
            state_d = S_DONE;
          end else begin
            if (j_last) begin
              j_d = '0;
              i_d = i_q + ONE_M;
            end else begin
              j_d = j_q + ONE_N;
            end
            state_d = S_STORE_RD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      m_q     <= m_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while rst_n is asserted so nothing leaks out from
  // a state that has not been cleared yet by the first reset edge.
  always_comb begin
    ld_ready_out         = 1'b0;
    st_ready_out         = 1'b0;
    ld_data_ready_out    = 1'b0;
    st_data_valid_out    = 1'b0;
    st_data_out          = '0;
    st_last_out          = 1'b0;
    busy_out             = 1'b0;
    done_out             = 1'b0;
    err_out              = 1'b0;
    reg_load_en_out      = 1'b0;
    reg_load_addr_out    = '0;
    reg_i_load_loc_out   = '0;
    reg_j_load_loc_out   = '0;
    reg_m_load_size_out  = '0;
    reg_n_load_size_out  = '0;
    reg_load_element_out = '0;
    reg_store_en_out     = 1'b0;
    reg_store_addr_out   = '0;
    reg_i_store_loc_out  = '0;
    reg_j_store_loc_out  = '0;

    if (rst_n) begin
      busy_out     = ~is_idle;
      err_out      = err_q;
      ld_ready_out = is_idle;
      st_ready_out = is_idle & ~ld_req_in;

      case (state_q)
        S_LOAD: begin
          ld_data_ready_out    = 1'b1;
          reg_load_en_out      = ld_data_valid_in;
          reg_load_addr_out    = addr_q;
          reg_i_load_loc_out   = i_q;
          reg_j_load_loc_out   = j_q;
          reg_m_load_size_out  = m_q;
          reg_n_load_size_out  = n_q;
          reg_load_element_out = ld_data_in;
        end

        S_STORE_RD: begin
          reg_store_en_out    = 1'b1;
          reg_store_addr_out  = addr_q;
          reg_i_store_loc_out = i_q;
          reg_j_store_loc_out = j_q;
        end

        S_STORE_OUT: begin
          st_data_valid_out = 1'b1;
          st_data_out       = reg_store_element_in;
          st_last_out       = elem_last;
        end

        S_DONE: begin
          done_out = 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_reg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mpu_reg_seq_ctrl
//
// Purpose
//   Self-checking bench for mpu_reg_seq_ctrl. A behavioural register file
//   answers the DUT's load/store ports; a reference model (row-major nested
//   loops over a per-register matrix array) supplies every expected value.
//   Directed scenarios plus randomized load/store round trips.
//
// Ports
//   none (top-level bench)
//
// Configuration
//   MPU_SEQ_BOUNDS_CHECK_EN  selects whether an oversized load is expected to
//                            be rejected (err_out pulse) or executed.
// ---------------------------------------------------------------------------

module tb_mpu_reg_seq_ctrl;

  localparam int MATRIX_REGISTERS = global_defs::MATRIX_REGISTERS;
  localparam int M                = global_defs::M;
  localparam int N                = global_defs::N;
  localparam int MBITS            = global_defs::MBITS;
  localparam int NBITS            = global_defs::NBITS;
  localparam int FP               = global_defs::FP;
  localparam int MATRIX_REG_SIZE  = global_defs::MATRIX_REG_SIZE;
  localparam int IDIM             = 1 << (MBITS + 1);
  localparam int JDIM             = 1 << (NBITS + 1);

  logic                       clk;
  logic                       rst_n;
  logic                       ld_req_in;
  logic                       ld_ready_out;
  logic [MATRIX_REG_SIZE-1:0] ld_addr_in;
  logic [MBITS:0]             ld_m_in;
  logic [NBITS:0]             ld_n_in;
  logic                       ld_data_valid_in;
  logic                       ld_data_ready_out;
  logic [FP-1:0]              ld_data_in;
  logic                       st_req_in;
  logic                       st_ready_out;
  logic [MATRIX_REG_SIZE-1:0] st_addr_in;
  logic [MBITS:0]             st_m_in;
  logic [NBITS:0]             st_n_in;
  logic                       st_data_valid_out;
  logic                       st_data_ready_in;
  logic [FP-1:0]              st_data_out;
  logic                       st_last_out;
  logic                       busy_out;
  logic                       done_out;
  logic                       err_out;
  logic                       reg_load_en_out;
  logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out;
  logic [MBITS:0]             reg_i_load_loc_out;
  logic [NBITS:0]             reg_j_load_loc_out;
  logic [MBITS:0]             reg_m_load_size_out;
  logic [NBITS:0]             reg_n_load_size_out;
  logic [FP-1:0]              reg_load_element_out;
  logic                       reg_store_en_out;
  logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out;
  logic [MBITS:0]             reg_i_store_loc_out;
  logic [NBITS:0]             reg_j_store_loc_out;
  logic [FP-1:0]              reg_store_element_in;

  int tests;
  int failures;

  // Behavioural register file seen by the DUT, and the reference contents.
  logic [FP-1:0] rf  [0:MATRIX_REGISTERS-1][0:IDIM-1][0:JDIM-1];
  logic [FP-1:0] mdl [0:MATRIX_REGISTERS-1][0:IDIM-1][0:JDIM-1];
  logic [FP-1:0] floatVals [0:5];

  mpu_reg_seq_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ld_req_in            (ld_req_in),
    .ld_ready_out         (ld_ready_out),
    .ld_addr_in           (ld_addr_in),
    .ld_m_in              (ld_m_in),
    .ld_n_in              (ld_n_in),
    .ld_data_valid_in     (ld_data_valid_in),
    .ld_data_ready_out    (ld_data_ready_out),
    .ld_data_in           (ld_data_in),
    .st_req_in            (st_req_in),
    .st_ready_out         (st_ready_out),
    .st_addr_in           (st_addr_in),
    .st_m_in              (st_m_in),
    .st_n_in              (st_n_in),
    .st_data_valid_out    (st_data_valid_out),
    .st_data_ready_in     (st_data_ready_in),
    .st_data_out          (st_data_out),
    .st_last_out          (st_last_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .err_out              (err_out),
    .reg_load_en_out      (reg_load_en_out),
    .reg_load_addr_out    (reg_load_addr_out),
    .reg_i_load_loc_out   (reg_i_load_loc_out),
    .reg_j_load_loc_out   (reg_j_load_loc_out),
    .reg_m_load_size_out  (reg_m_load_size_out),
    .reg_n_load_size_out  (reg_n_load_size_out),
    .reg_load_element_out (reg_load_element_out),
    .reg_store_en_out     (reg_store_en_out),
    .reg_store_addr_out   (reg_store_addr_out),
    .reg_i_store_loc_out  (reg_i_store_loc_out),
    .reg_j_store_loc_out  (reg_j_store_loc_out),
    .reg_store_element_in (reg_store_element_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: element writes, and registered reads held while idle.
  always @(posedge clk) begin
    if (reg_load_en_out)
      rf[reg_load_addr_out][reg_i_load_loc_out][reg_j_load_loc_out] <= reg_load_element_out;
    if (reg_store_en_out)
      reg_store_element_in <= rf[reg_store_addr_out][reg_i_store_loc_out][reg_j_store_loc_out];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Full load command; expected beats come from row-major nested loops.
  task automatic doLoad(input int addr, input int m, input int n, input bit allValid, input bit useFloat);
    logic [FP-1:0] qElem[$];
    int            qI[$];
    int            qJ[$];
    int            cycles;
    bit            v;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        qI.push_back(r);
        qJ.push_back(c);
        qElem.push_back(useFloat ? floatVals[r * n + c] : FP'($urandom));
      end
    end
    ld_req_in        = 1'b1;
    ld_addr_in       = MATRIX_REG_SIZE'(addr);
    ld_m_in          = (MBITS+1)'(m);
    ld_n_in          = (NBITS+1)'(n);
    ld_data_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("ld_ready_accept", ld_ready_out, 1);
    checkOutput("st_ready_blocked", st_ready_out, 0);
    checkOutput("busy_accept", busy_out, 0);
    checkOutput("done_accept", done_out, 0);
    applyStimulus();
    ld_req_in = 1'b0;
    cycles = 0;
    while (qElem.size() > 0 && cycles < 200) begin
      v = allValid || ($urandom_range(3) != 0);
      ld_data_valid_in = v;
      ld_data_in       = v ? qElem[0] : FP'($urandom);
      @(negedge clk);
      checkOutput("ld_data_ready", ld_data_ready_out, 1);
      checkOutput("ld_en", reg_load_en_out, v);
      checkOutput("ld_busy", busy_out, 1);
      checkOutput("ld_err", err_out, 0);
      checkOutput("ld_st_ready", st_ready_out, 0);
      if (v) begin
        checkOutput("ld_addr", reg_load_addr_out, addr);
        checkOutput("ld_i", reg_i_load_loc_out, qI[0]);
        checkOutput("ld_j", reg_j_load_loc_out, qJ[0]);
        checkOutput("ld_m", reg_m_load_size_out, m);
        checkOutput("ld_n", reg_n_load_size_out, n);
        checkOutput("ld_elem", reg_load_element_out, qElem[0]);
        mdl[addr][qI[0]][qJ[0]] = qElem[0];
        void'(qElem.pop_front());
        void'(qI.pop_front());
        void'(qJ.pop_front());
      end
      applyStimulus();
      cycles++;
    end
    checkOutput("ld_all_beats", qElem.size(), 0);
    ld_data_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("ld_done_pulse", done_out, 1);
    checkOutput("ld_en_in_done", reg_load_en_out, 0);
    applyStimulus();
  endtask

  // Full store command; stallAt/stallLen holds ready low on one element.
  task automatic doStore(input int addr, input int m, input int n, input int stallAt, input int stallLen, input bit randStall);
    int  stall;
    bit  last;
    st_req_in = 1'b1;
    ld_req_in = 1'b0;
    st_addr_in = MATRIX_REG_SIZE'(addr);
    st_m_in    = (MBITS+1)'(m);
    st_n_in    = (NBITS+1)'(n);
    @(negedge clk);
    checkOutput("st_ready_accept", st_ready_out, 1);
    checkOutput("st_busy_accept", busy_out, 0);
    checkOutput("st_done_accept", done_out, 0);
    applyStimulus();
    st_req_in        = 1'b0;
    st_data_ready_in = 1'b0;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        last = (r == m - 1) && (c == n - 1);
        @(negedge clk);
        checkOutput("st_rd_en", reg_store_en_out, 1);
        checkOutput("st_rd_addr", reg_store_addr_out, addr);
        checkOutput("st_rd_i", reg_i_store_loc_out, r);
        checkOutput("st_rd_j", reg_j_store_loc_out, c);
        checkOutput("st_rd_valid", st_data_valid_out, 0);
        applyStimulus();
        stall = (r * n + c == stallAt) ? stallLen : (randStall ? int'($urandom_range(2)) : 0);
        for (int s = 0; s <= stall; s++) begin
          st_data_ready_in = (s == stall);
          @(negedge clk);
          checkOutput("st_valid", st_data_valid_out, 1);
          checkOutput("st_data", st_data_out, mdl[addr][r][c]);
          checkOutput("st_last", st_last_out, last);
          checkOutput("st_no_rd_en", reg_store_en_out, 0);
          checkOutput("st_busy", busy_out, 1);
          applyStimulus();
        end
        st_data_ready_in = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("st_done_pulse", done_out, 1);
    checkOutput("st_valid_in_done", st_data_valid_out, 0);
    applyStimulus();
  endtask

  initial begin
    int addr;
    int m;
    int n;
    tests    = 0;
    failures = 0;
    floatVals[0] = 32'h3F80_0000;
    floatVals[1] = 32'h4000_0000;
    floatVals[2] = 32'h4040_0000;
    floatVals[3] = 32'h4080_0000;
    floatVals[4] = 32'h40A0_0000;
    floatVals[5] = 32'h40C0_0000;

    rst_n            = 1'b0;
    ld_req_in        = 1'b0;
    ld_addr_in       = '0;
    ld_m_in          = '0;
    ld_n_in          = '0;
    ld_data_valid_in = 1'b0;
    ld_data_in       = '0;
    st_req_in        = 1'b0;
    st_addr_in       = '0;
    st_m_in          = '0;
    st_n_in          = '0;
    st_data_ready_in = 1'b0;

    // Power-on reset.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("por_busy", busy_out, 0);
      checkOutput("por_ld_ready", ld_ready_out, 0);
      checkOutput("por_done", done_out, 0);
      applyStimulus();
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy_out, 0);
    checkOutput("idle_ld_ready", ld_ready_out, 1);
    checkOutput("idle_err", err_out, 0);
    applyStimulus();

    // Directed 2x3 float load into register 1, then store it back.
    doLoad(1, 2, 3, 1'b1, 1'b1);
    doStore(1, 2, 3, -1, 0, 1'b0);

    // Reset held 3 cycles in the middle of a 3x3 load.
    ld_req_in  = 1'b1;
    ld_addr_in = MATRIX_REG_SIZE'(2);
    ld_m_in    = (MBITS+1)'(3);
    ld_n_in    = (NBITS+1)'(3);
    applyStimulus();
    ld_req_in        = 1'b0;
    ld_data_valid_in = 1'b1;
    ld_data_in       = FP'($urandom);
    applyStimulus();
    applyStimulus();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_busy", busy_out, 0);
      checkOutput("rst_ld_en", reg_load_en_out, 0);
      checkOutput("rst_ld_data_ready", ld_data_ready_out, 0);
      checkOutput("rst_ld_ready", ld_ready_out, 0);
      checkOutput("rst_st_valid", st_data_valid_out, 0);
      checkOutput("rst_done", done_out, 0);
      applyStimulus();
    end
    rst_n            = 1'b1;
    ld_data_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", busy_out, 0);
    checkOutput("post_rst_ld_ready", ld_ready_out, 1);
    checkOutput("post_rst_ld_en", reg_load_en_out, 0);
    applyStimulus();
    doLoad(2, 2, 2, 1'b1, 1'b0);
    doStore(2, 2, 2, -1, 0, 1'b0);

    // 3x3 store with a 4-cycle stall on element (1,1).
    doLoad(4, 3, 3, 1'b0, 1'b0);
    doStore(4, 3, 3, 4, 4, 1'b0);

    // Load and store requested together: load first, store right after.
    st_req_in  = 1'b1;
    st_addr_in = MATRIX_REG_SIZE'(5);
    st_m_in    = (MBITS+1)'(2);
    st_n_in    = (NBITS+1)'(2);
    doLoad(5, 2, 2, 1'b1, 1'b0);
    doStore(5, 2, 2, -1, 0, 1'b0);

    // Randomized round trips.
    for (int t = 0; t < 5; t++) begin
      addr = int'($urandom_range(MATRIX_REGISTERS - 1));
      m    = int'($urandom_range(M, 1));
      n    = int'($urandom_range(N, 1));
      doLoad(addr, m, n, 1'b0, 1'b0);
      doStore(addr, m, n, -1, 0, 1'b1);
    end

    // Oversized load: m = M+1.
`ifdef MPU_SEQ_BOUNDS_CHECK_EN
    ld_req_in        = 1'b1;
    ld_addr_in       = MATRIX_REG_SIZE'(3);
    ld_m_in          = (MBITS+1)'(M + 1);
    ld_n_in          = (NBITS+1)'(2);
    ld_data_valid_in = 1'b1;
    @(negedge clk);
    checkOutput("bad_ld_ready", ld_ready_out, 1);
    checkOutput("bad_err_early", err_out, 0);
    applyStimulus();
    ld_req_in = 1'b0;
    @(negedge clk);
    checkOutput("bad_err_pulse", err_out, 1);
    checkOutput("bad_busy", busy_out, 0);
    checkOutput("bad_ld_en", reg_load_en_out, 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("bad_err_clear", err_out, 0);
    checkOutput("bad_busy2", busy_out, 0);
    checkOutput("bad_ld_en2", reg_load_en_out, 0);
    applyStimulus();
    ld_data_valid_in = 1'b0;
`else
    doLoad(3, M + 1, 2, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("big_err", err_out, 0);
    checkOutput("big_busy", busy_out, 0);
    applyStimulus();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
